// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder/subtractor: walks CHUNKS 6-bit slices through an
// external 6-bit adder, one slice per clock, LSB slice first.
module wide_add_seq #(
   parameter int unsigned CHUNKS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [6*CHUNKS-1:0]   op_a,
   input  logic [6*CHUNKS-1:0]   op_b,
   input  logic                  cin,
   input  logic                  sub,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [6*CHUNKS-1:0]   res_sum,
   output logic                  res_cout,
   output logic                  res_ovf,
   output logic                  add_en,
   output logic [5:0]            add_a,
   output logic [5:0]            add_b,
   output logic                  add_cin,
   input  logic [6:0]            add_res
);

   localparam int unsigned W  = 6 * CHUNKS;
   localparam int unsigned KW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(CHUNKS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, b_q;
   logic          carry_q;
   logic [KW-1:0] k_q;
   logic          last;
   logic [5:0]    a_sel, b_sel;

   assign last = (k_q == K_LAST);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      start_ready = 1'b0;
      res_valid   = 1'b0;
      add_en      = 1'b0;
      add_a       = '0;
      add_b       = '0;
      add_cin     = 1'b0;
      unique case (state_q)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid) state_d = RUN;
         end
         RUN: begin
            add_en  = 1'b1;
            add_a   = a_sel;
            add_b   = b_sel;
            add_cin = carry_q;
            if (last) state_d = DONE;
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Slice selection by chunk index, kept as a compare-per-chunk mux.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int unsigned i = 0; i < CHUNKS; i++) begin
         if (k_q == KW'(i)) begin
            a_sel = a_q[6*i +: 6];
            b_sel = b_q[6*i +: 6];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         k_q      <= '0;
         res_sum  <= '0;
         res_cout <= 1'b0;
         res_ovf  <= 1'b0;
      end else begin
         if (state_q == IDLE && start_valid) begin
            a_q     <= op_a;
            b_q     <= sub ? ~op_b : op_b;
            carry_q <= sub ? 1'b1 : cin;
            k_q     <= '0;
         end else if (state_q == RUN) begin
            for (int unsigned i = 0; i < CHUNKS; i++) begin
               if (k_q == KW'(i)) res_sum[6*i +: 6] <= add_res[5:0];
            end
            carry_q <= add_res[6];
            if (last) begin
               res_cout <= add_res[6];
               res_ovf  <= (a_q[W-1] == b_q[W-1]) && (add_res[5] != a_q[W-1]);
            end else begin
               k_q <= k_q + 1'b1;
            end
         end
      end
   end

endmodule
